minmax_tracker: RTL and testbench

- Downstream consumer of the magnitude-comparator flags (greater/less).
- Accepts a stream of unsigned W-bit samples over a valid/ready handshake.
- Tracks the running maximum and minimum, with their indices, over a programmable window.
- Presents the result on a held valid/ready output port.

---
 rtl/minmax_pkg.sv | 16 +
 rtl/mag_cmp.sv | 17 +
 rtl/minmax_tracker.sv | 182 ++++++++++++++++++
 tb/tb_minmax_tracker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max window tracker.
//   state_t   : tracker FSM states (IDLE, COLLECT, HOLD)
//   W_DEF     : default sample width in bits
//   N_MAX_DEF : default largest legal window length
package minmax_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned N_MAX_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator, purely combinational.
//   a, b    : W-bit unsigned operands
//   greater : a > b
//   less    : a < b   (both flags low when a == b)
module mag_cmp #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         greater,
    output logic         less
);

    assign greater = (a > b);
    assign less    = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Running maximum/minimum tracker over a programmable window of unsigned
// samples. A window is opened with start/win_len in IDLE, samples are taken
// over a valid/ready handshake in COLLECT, and the result is held on a
// valid/ready output port in HOLD until the consumer takes it.
//   clk, rst            : clock, asynchronous active-high reset
//   start, win_len      : window request and its length (1..N_MAX)
//   in_valid/in_ready   : sample handshake, in_data is the sample
//   out_valid/out_ready : result handshake
//   out_max, out_min    : extremes of the window
//   out_max_idx/min_idx : 0-based index of the first occurrence of each
//   busy                : high in COLLECT or HOLD
//   err                 : one-cycle pulse when start carries an illegal win_len
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned N_MAX = N_MAX_DEF,
    parameter int unsigned CNT_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [W-1:0]     out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] len_r;
    logic [W-1:0]     max_r;
    logic [W-1:0]     min_r;
    logic [CNT_W-1:0] max_idx_r;
    logic [CNT_W-1:0] min_idx_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             err_r;

    logic             gt_max_s;
    logic             lt_max_s;
    logic             gt_min_s;
    logic             lt_min_s;
    logic             accept_s;
    logic             win_ok_s;
    logic             last_s;

    // Sample against the current maximum; only the strict-greater flag is used.
    mag_cmp #(.W(W)) u_cmp_max (
        .a       (in_data),
        .b       (max_r),
        .greater (gt_max_s),
        .less    (lt_max_s)
    );

    // Sample against the current minimum; only the strict-less flag is used.
    mag_cmp #(.W(W)) u_cmp_min (
        .a       (in_data),
        .b       (min_r),
        .greater (gt_min_s),
        .less    (lt_min_s)
    );

    // Handshake qualification and window-length legality.
    always_comb begin
        accept_s = 1'b0;
        win_ok_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == COLLECT) begin
            accept_s = in_valid && in_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        if ((win_len != ZERO_C) && (win_len <= N_MAX_C)) begin
            win_ok_s = 1'b1;
        end else begin
            win_ok_s = 1'b0;
        end
        if (count_r == (len_r - ONE_C)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Tracker FSM with all outputs registered; the result registers keep
    // their values through IDLE until the next window's first accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= ZERO_C;
            len_r       <= ZERO_C;
            max_r       <= {W{1'b0}};
            min_r       <= {W{1'b0}};
            max_idx_r   <= ZERO_C;
            min_idx_r   <= ZERO_C;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (win_ok_s) begin
                            len_r      <= win_len;
                            count_r    <= ZERO_C;
                            state_r    <= COLLECT;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept_s) begin
                        count_r <= count_r + ONE_C;
                        if (count_r == ZERO_C) begin
                            max_r     <= in_data;
                            min_r     <= in_data;
                            max_idx_r <= ZERO_C;
                            min_idx_r <= ZERO_C;
                        end else begin
                            // Strict compares so ties keep the earliest index.
                            if (gt_max_s) begin
                                max_r     <= in_data;
                                max_idx_r <= count_r;
                            end
                            if (lt_min_s) begin
                                min_r     <= in_data;
                                min_idx_r <= count_r;
                            end
                        end
                        if (last_s) begin
                            state_r     <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_max     = max_r;
    assign out_min     = min_r;
    assign out_max_idx = max_idx_r;
    assign out_min_idx = min_idx_r;
    assign busy        = busy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: hand-computed expected results for a
// sequence of windows covering reset, ties, gaps, backpressure, illegal
// window lengths and the length boundaries.
module tb_minmax_tracker;

    localparam int unsigned W     = 8;
    localparam int unsigned N_MAX = 16;
    localparam int unsigned CNT_W = $clog2(N_MAX + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] win_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_max;
    logic [W-1:0]     out_min;
    logic [CNT_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_min_idx;
    logic             busy;
    logic             err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    minmax_tracker #(.W(W), .N_MAX(N_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .win_len     (win_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] mx, input logic [31:0] mxi,
                           input logic [31:0] mn, input logic [31:0] mni);
        check({tag, "_valid"},   32'(out_valid),   32'h1);
        check({tag, "_max"},     32'(out_max),     mx);
        check({tag, "_max_idx"}, 32'(out_max_idx), mxi);
        check({tag, "_min"},     32'(out_min),     mn);
        check({tag, "_min_idx"}, 32'(out_min_idx), mni);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_drop_busy"},  32'(busy),      32'h0);
    endtask

    initial begin
        // Power-on reset state.
        tick();
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_err",       32'(err),       32'h0);
        rst = 1'b0;
        tick();

        // Reset mid-window after 3 of 5 samples.
        do_start(5'd5);
        check("start_busy",     32'(busy),     32'h1);
        check("start_in_ready", 32'(in_ready), 32'h1);
        send(8'h11);
        send(8'h33);
        send(8'h22);
        check("mid_max", 32'(out_max), 32'h33);
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready),    32'h0);
        check("arst_busy",     32'(busy),        32'h0);
        check("arst_max",      32'(out_max),     32'h0);
        check("arst_min",      32'(out_min),     32'h0);
        check("arst_max_idx",  32'(out_max_idx), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        do_start(5'd2);
        send(8'h10);
        send(8'h20);
        chk_res("post_rst", 32'h20, 32'h1, 32'h10, 32'h0);
        consume("post_rst");

        // Basic window, continuous valid; out_valid one cycle after 4th accept.
        do_start(5'd4);
        send(8'h05);
        send(8'hF0);
        send(8'h00);
        check("basic_no_early_valid", 32'(out_valid), 32'h0);
        send(8'h7F);
        chk_res("basic", 32'hF0, 32'h1, 32'h00, 32'h2);
        consume("basic");
        check("idle_hold_max", 32'(out_max), 32'hF0);

        // Ties keep earliest index.
        do_start(5'd5);
        send(8'hFF);
        send(8'h00);
        send(8'hFF);
        send(8'h00);
        send(8'h80);
        chk_res("ties", 32'hFF, 32'h0, 32'h00, 32'h1);
        consume("ties");

        // Gaps in valid, then backpressure with stray samples and a stray start.
        do_start(5'd3);
        send(8'd3);
        tick();
        send(8'd9);
        tick();
        check("gap_not_done", 32'(out_valid), 32'h0);
        send(8'd1);
        chk_res("gaps", 32'd9, 32'h1, 32'd1, 32'h2);
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid",    32'(out_valid), 32'h1);
            check("bp_in_ready", 32'(in_ready),  32'h0);
            check("bp_max",      32'(out_max),   32'd9);
            check("bp_min",      32'(out_min),   32'd1);
        end
        in_valid = 1'b0;
        do_start(5'd0);
        check("hold_start_err",   32'(err),       32'h0);
        check("hold_start_valid", 32'(out_valid), 32'h1);
        check("hold_start_busy",  32'(busy),      32'h1);
        consume("bp");

        // Illegal window lengths.
        do_start(5'd0);
        check("len0_err",  32'(err),  32'h1);
        check("len0_busy", 32'(busy), 32'h0);
        tick();
        check("len0_err_clear", 32'(err), 32'h0);
        do_start(5'd17);
        check("len17_err",  32'(err),  32'h1);
        check("len17_busy", 32'(busy), 32'h0);
        tick();
        check("len17_err_clear", 32'(err), 32'h0);

        // Largest window: 15 down to 0.
        do_start(5'd16);
        for (int i = 0; i < 16; i++) begin
            send(8'(15 - i));
        end
        chk_res("len16", 32'd15, 32'h0, 32'd0, 32'd15);
        consume("len16");

        // Single-sample window.
        do_start(5'd1);
        send(8'h42);
        chk_res("len1", 32'h42, 32'h0, 32'h42, 32'h0);
        consume("len1");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
